// File: rtl/apb_rr_requester_pkg.sv
// Shared types and constants for the round-robin APB requester.
// The FSM encoding and the response status codes live here so every file agrees on them.
package apb_rr_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_req_state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

endpackage

// File: rtl/apb_rr_requester_if.sv
// Bundles the client command/response ports and the APB completer port of the requester.
// The master modport is the requester's view; the slave modport is the environment's view.
interface apb_rr_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic [ADDR_WIDTH-1:0]         PADDR;
  logic                          PWRITE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic                          PSEL;
  logic                          PENABLE;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PREADY;
  logic                          PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

endinterface

// File: rtl/apb_rr_requester_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr, wrapping.
// The pointer register itself is owned by the parent.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // Scan from the farthest offset down so the closest request to ptr is the last one written.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (req[IW'(idx)]) begin
        gnt          = '0;
        gnt[IW'(idx)] = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_rr_requester.sv
// APB requester shared by NUM_REQ clients: round-robin grant, SETUP/ACCESS sequencing,
// one-cycle response pulse to the granted client, and abort of transfers the completer never finishes.
module apb_rr_requester
  import apb_rr_requester_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 16
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb_rr_requester_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_req_state_t        state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]         tcnt_q, tcnt_d;
  logic [CW-1:0]         tcnt_inc;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          state_d  = SETUP;
          owner_d  = gnt_idx;
          ptr_d    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          paddr_d  = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d = bus.req_write[gnt_idx];
          pwdata_d = bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
          tcnt_d   = '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PSLVERR only means something in the cycle PREADY is high.
        if (bus.PREADY) begin
          state_d     = IDLE;
          tcnt_d      = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = (pwrite_q || bus.PSLVERR) ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR ? APB_ERR : APB_OKAY;
        end else if (tcnt_inc == CW'(TIMEOUT)) begin
          state_d     = IDLE;
          tcnt_d      = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_rdata_d = '0;
          rsp_err_d   = APB_ERR;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? gnt : '0;
  assign bus.PSEL      = (state_q != IDLE);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_requester.sv
// Self-checking bench for apb_rr_requester: directed vector table, round-robin and reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_apb_rr_requester;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TO = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_rr_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  apb_rr_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Completer model: configurable wait states, a hang switch, and an erroring address (40).
  logic [DW-1:0] mem [0:31];
  int            accessCycles;
  int            waitCfg = 0;
  logic          hang    = 1'b0;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      accessCycles <= 0;
    end else begin
      if (!bus.PSEL || !bus.PENABLE || bus.PREADY) accessCycles <= 0;
      else accessCycles <= accessCycles + 1;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
        mem[bus.PADDR[6:2]] <= bus.PWDATA;
    end
  end

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && !hang && (accessCycles >= waitCfg);
  assign bus.PSLVERR = bus.PREADY && (bus.PADDR == 32'd40);
  assign bus.PRDATA  = (bus.PADDR == 32'd40) ? 32'hBAD0BAD0 : mem[bus.PADDR[6:2]];

  typedef struct {
    int          client;
    logic        write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int          waits;
    logic        hang;
    logic [DW-1:0] expRdata;
    logic        expErr;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int c, input logic v, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[c]         = v;
    bus.req_write[c]         = w;
    bus.req_addr[c*AW +: AW] = a;
    bus.req_wdata[c*DW +: DW] = d;
  endtask

  task automatic resetDut();
    @(negedge PCLK);
    #2;
    PRESETn       = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    hang          = 1'b0;
    waitCfg       = 0;
    repeat (2) @(negedge PCLK);
    #2;
    PRESETn = 1'b1;
  endtask

  task automatic runOne(input vec_t v, input int n);
    logic [NR-1:0] oneHot;
    logic          found;
    oneHot = NR'(1) << v.client;
    @(posedge PCLK);
    #1;
    waitCfg = v.waits;
    hang    = v.hang;
    applyStimulus(v.client, 1'b1, v.write, v.addr, v.wdata);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge PCLK);
      if (|bus.req_ready) found = 1'b1;
    end
    checkOutput($sformatf("v%0d_grant", n), 128'(bus.req_ready), 128'(oneHot));
    @(posedge PCLK);
    #1;
    applyStimulus(v.client, 1'b0, v.write, v.addr, v.wdata);
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge PCLK);
      if (k < v.lat)
        checkOutput($sformatf("v%0d_hold_c%0d", n, k),
                    128'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.PADDR, bus.PWDATA}),
                    128'({1'b1, (k >= 2), v.write, 2'b00, v.addr, v.wdata}));
      else
        checkOutput($sformatf("v%0d_rsp", n),
                    128'({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
                    128'({2'b00, oneHot, v.expErr, v.expRdata}));
    end
  endtask

  task automatic rrTest();
    int expC, grants, last;
    resetDut();
    @(posedge PCLK);
    #1;
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'd4, 32'd0);
    expC = 0; grants = 0; last = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge PCLK);
      if (|bus.req_ready) begin
        checkOutput("rr_alt", 128'(bus.req_ready), 128'(NR'(1) << expC));
        if (grants > 0) checkOutput("rr_gap", 128'(c - last), 128'(3));
        last = c;
        grants++;
        expC = 1 - expC;
      end
    end
    checkOutput("rr_count", 128'(grants), 128'(10));
    @(posedge PCLK);
    #1;
    bus.req_valid = '0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic resetMidTest();
    logic found, stale;
    resetDut();
    @(posedge PCLK);
    #1;
    hang = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'd8, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge PCLK);
      if (bus.req_ready[0]) found = 1'b1;
    end
    @(posedge PCLK);
    #1;
    applyStimulus(0, 1'b0, 1'b0, 32'd8, 32'd0);
    for (int k = 0; k < 10 && !bus.PENABLE; k++) @(negedge PCLK);
    checkOutput("rst_in_access", 128'(bus.PENABLE), 128'(1));
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("rst_abort", 128'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 128'(0));
    repeat (2) @(negedge PCLK);
    #2;
    hang    = 1'b0;
    PRESETn = 1'b1;
    stale   = 1'b0;
    repeat (8) begin
      @(negedge PCLK);
      if (|bus.rsp_valid || bus.PSEL) stale = 1'b1;
    end
    checkOutput("rst_no_stale", 128'(stale), 128'(0));
    @(posedge PCLK);
    #1;
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'd4, 32'd0);
    @(negedge PCLK);
    checkOutput("rst_ptr", 128'(bus.req_ready), 128'(2'b01));
    @(posedge PCLK);
    #1;
    bus.req_valid = '0;
    repeat (4) @(negedge PCLK);
  endtask

  // Transaction-level model: a transfer granted at cycle c with w wait states answers at c+3+w,
  // and the bus is free again that same cycle.
  task automatic randomTest();
    logic [DW-1:0] refMem [0:31];
    logic          vValid [NR];
    logic          vWrite [NR];
    logic [AW-1:0] vAddr  [NR];
    logic [DW-1:0] vData  [NR];
    int            cyc, nextFree, rrPtr, granted, w, idx, cand;
    logic          pendValid, pendErr;
    int            pendCycle, pendClient;
    logic [DW-1:0] pendData;
    logic [NR-1:0] expRsp, expReady;
    resetDut();
    for (int i = 0; i < 32; i++) refMem[i] = '0;
    for (int c = 0; c < NR; c++) begin
      vValid[c] = 1'b0; vWrite[c] = 1'b0; vAddr[c] = '0; vData[c] = '0;
    end
    cyc = 0; nextFree = 0; rrPtr = 0;
    pendValid = 1'b0; pendErr = 1'b0; pendCycle = 0; pendClient = 0; pendData = '0;
    @(posedge PCLK);
    #1;
    for (int it = 0; it < 400; it++) begin
      @(negedge PCLK);
      cyc++;
      expRsp = '0;
      if (pendValid && pendCycle == cyc) begin
        expRsp    = NR'(1) << pendClient;
        pendValid = 1'b0;
        checkOutput("rnd_rsp_data", 128'({bus.rsp_err, bus.rsp_rdata}), 128'({pendErr, pendData}));
      end
      checkOutput("rnd_rsp_valid", 128'(bus.rsp_valid), 128'(expRsp));
      expReady = '0;
      granted  = -1;
      if (cyc >= nextFree)
        for (int o = 0; o < NR && granted < 0; o++) begin
          cand = (rrPtr + o) % NR;
          if (vValid[cand]) granted = cand;
        end
      if (granted >= 0) begin
        expReady = NR'(1) << granted;
        w        = int'($urandom_range(0, 2));
        waitCfg  = w;
        idx      = int'(vAddr[granted][6:2]);
        if (vAddr[granted] == 32'd40) begin
          pendErr = 1'b1; pendData = '0;
        end else if (vWrite[granted]) begin
          refMem[idx] = vData[granted]; pendErr = 1'b0; pendData = '0;
        end else begin
          pendErr = 1'b0; pendData = refMem[idx];
        end
        pendValid  = 1'b1;
        pendCycle  = cyc + 3 + w;
        pendClient = granted;
        nextFree   = cyc + 3 + w;
        rrPtr      = (granted + 1) % NR;
      end
      checkOutput("rnd_ready", 128'(bus.req_ready), 128'(expReady));
      @(posedge PCLK);
      #1;
      for (int c = 0; c < NR; c++) begin
        if (c == granted) begin
          vValid[c] = 1'b0;
        end else if (!vValid[c] && it < 360 && $urandom_range(0, 2) == 0) begin
          vValid[c] = 1'b1;
          vWrite[c] = 1'($urandom_range(0, 1));
          vAddr[c]  = ($urandom_range(0, 9) == 0) ? 32'd40 : AW'($urandom_range(0, 15) * 4);
          vData[c]  = DW'($urandom);
        end
        applyStimulus(c, vValid[c], vWrite[c], vAddr[c], vData[c]);
      end
    end
    checkOutput("rnd_drain", 128'(pendValid), 128'(0));
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 32'd4,  32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 3};
    vecs[1] = '{0, 1'b0, 32'd4,  32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    vecs[2] = '{1, 1'b1, 32'd8,  32'h12345678, 3, 1'b0, 32'h0,        1'b0, 6};
    vecs[3] = '{1, 1'b0, 32'd8,  32'h0,        3, 1'b0, 32'h12345678, 1'b0, 6};
    vecs[4] = '{0, 1'b0, 32'd40, 32'h0,        0, 1'b0, 32'h0,        1'b1, 3};
    vecs[5] = '{1, 1'b1, 32'd40, 32'hCAFEF00D, 1, 1'b0, 32'h0,        1'b1, 4};
    vecs[6] = '{0, 1'b0, 32'd4,  32'h0,        0, 1'b1, 32'h0,        1'b1, TO + 2};
    vecs[7] = '{1, 1'b0, 32'd4,  32'h0,        2, 1'b0, 32'hDEADBEEF, 1'b0, 5};

    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(negedge PCLK);
    checkOutput("reset_during",
                128'({bus.PSEL, bus.PENABLE, bus.req_ready, bus.rsp_valid, bus.rsp_err,
                      bus.rsp_rdata, bus.PADDR, bus.PWRITE, bus.PWDATA}), 128'(0));
    #13;
    PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("reset_after",
                128'({bus.PSEL, bus.PENABLE, bus.req_ready, bus.rsp_valid, bus.rsp_err,
                      bus.rsp_rdata, bus.PADDR, bus.PWRITE, bus.PWDATA}), 128'(0));

    for (int i = 0; i < 8; i++) runOne(vecs[i], i);
    rrTest();
    resetMidTest();
    randomTest();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
